// File: rtl/bin_to_bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_pkg
//  Description : Shared types and constants for the sequential binary-to-BCD
//                (double-dabble) converter.
//                - state_t    : converter FSM states
//                - BIN_WIDTH  : binary input width (fixed 8 in this revision)
//                - ITER       : shift iterations per conversion
//                - BCD_DIGITS : number of packed BCD output digits
//                - SR_WIDTH   : combined BCD + binary shift register width
//  Revision    : 1.0 - initial release
// ============================================================================
package bin_to_bcd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int BIN_WIDTH  = 8;
    localparam int ITER       = BIN_WIDTH;
    localparam int BCD_DIGITS = 3;
    localparam int BCD_WIDTH  = 4 * BCD_DIGITS;
    localparam int SR_WIDTH   = BCD_WIDTH + BIN_WIDTH;
    localparam int CNT_WIDTH  = $clog2(ITER);

    // Double-dabble digit correction: a digit of 5..9 becomes 8..12 so that
    // the following left shift carries into the next decimal digit.  Inputs
    // never exceed 9, so the 4-bit sum cannot overflow.
    function automatic logic [3:0] nibble_adjust(input logic [3:0] digit);
        if (digit >= 4'd5) begin
            return digit + 4'd3;
        end
        return digit;
    endfunction

endpackage : bin_to_bcd_pkg
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_add3
//  Description : Combinational add-3 correction for one BCD digit.
//                Ports:
//                  din  [3:0] : BCD digit before correction (0..9)
//                  dout [3:0] : din + 3 when din >= 5, else din
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3
    import bin_to_bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = nibble_adjust(din);
    end

endmodule : bcd_add3
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_seq
//  Description : Sequential shift-add-3 converter from an 8-bit binary value
//                to three packed BCD digits {hundreds, tens, ones}.  One bit
//                is processed per clock, so a conversion takes ITER clocks.
//                bcd/ovf are only written on the final iteration, so a
//                downstream display never sees a partial result.
//                Ports:
//                  clk   : system clock
//                  rst   : synchronous reset, active-high
//                  bin   : binary value, sampled when a conversion starts
//                  start : conversion request, honoured only in IDLE
//                  busy  : high while a conversion is in progress
//                  done  : one-cycle pulse when bcd/ovf update
//                  bcd   : {hundreds, tens, ones} packed BCD
//                  ovf   : converted value > 99 (hundreds digit non-zero)
//                Parameters:
//                  IN_WIDTH : binary input width (8 in this revision)
//                  AUTO     : 1 = convert whenever bin differs from the last
//                             converted value, 0 = convert only on start
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
    import bin_to_bcd_pkg::*;
#(
    parameter int IN_WIDTH = BIN_WIDTH,
    parameter bit AUTO     = 1'b0
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  bin,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [BCD_WIDTH-1:0] bcd,
    output logic                 ovf
);

    localparam logic [CNT_WIDTH-1:0] c_LAST_ITER = CNT_WIDTH'(ITER - 1);

    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [SR_WIDTH-1:0]   r_sr;
    logic [IN_WIDTH-1:0]   r_last;

    logic [SR_WIDTH-1:0]   w_adj;
    logic [SR_WIDTH-1:0]   w_shifted;
    logic                  w_auto_trig;
    logic                  w_trigger;

    // ------------------------------------------------------------------
    // Per-digit correction on the BCD part of the shift register; the
    // binary part passes through untouched.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
        bcd_add3 u_add3 (
            .din  (r_sr [BIN_WIDTH + 4*g +: 4]),
            .dout (w_adj[BIN_WIDTH + 4*g +: 4])
        );
    end

    assign w_adj[BIN_WIDTH-1:0] = r_sr[BIN_WIDTH-1:0];

    // The top bit shifted out is always zero: the hundreds digit of an
    // 8-bit value never exceeds 2, so its adjusted form stays below 8.
    assign w_shifted = w_adj << 1;

    // In AUTO mode a fresh value is detected against the last one actually
    // converted, so a bin change during SHIFT is picked up once back in IDLE.
    // A simultaneous start and auto trigger collapse into one conversion.
    assign w_auto_trig = AUTO && (bin != r_last);
    assign w_trigger   = start || w_auto_trig;

    // ------------------------------------------------------------------
    // Control FSM, iteration counter, shift register and registered
    // outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sr    <= '0;
            r_last  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        r_sr    <= {{BCD_WIDTH{1'b0}}, bin};
                        r_cnt   <= '0;
                        r_last  <= bin;
                        busy    <= 1'b1;
                        r_state <= SHIFT;
                    end
                end

                SHIFT: begin
                    r_sr  <= w_shifted;
                    r_cnt <= r_cnt + 1'b1;
                    // The final result is taken from the combinational
                    // shifted value so that bcd lands on the same edge
                    // that ends the conversion.
                    if (r_cnt == c_LAST_ITER) begin
                        bcd     <= w_shifted[SR_WIDTH-1 -: BCD_WIDTH];
                        ovf     <= |w_shifted[SR_WIDTH-1 -: 4];
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : bin_to_bcd_seq
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin_to_bcd_seq
//  Description : Self-checking bench for bin_to_bcd_seq.  A start-driven
//                instance (AUTO=0) and an auto-triggered instance (AUTO=1)
//                share clock and reset.  Expected digits come from plain
//                decimal arithmetic on the applied value.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [7:0]  bin0 = 8'd0;
    logic        start0 = 1'b0;
    logic        busy0, done0, ovf0;
    logic [11:0] bcd0;

    logic [7:0]  bin1 = 8'd0;
    logic        start1 = 1'b0;
    logic        busy1, done1, ovf1;
    logic [11:0] bcd1;

    int          n_vec = 0;
    int          n_err = 0;
    logic [11:0] exp0 = 12'h000;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.IN_WIDTH(8), .AUTO(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .bin(bin0), .start(start0),
        .busy(busy0), .done(done0), .bcd(bcd0), .ovf(ovf0)
    );

    bin_to_bcd_seq #(.IN_WIDTH(8), .AUTO(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .bin(bin1), .start(start1),
        .busy(busy1), .done(done1), .bcd(bcd1), .ovf(ovf1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: decimal digits by division
    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Advance one clock; outputs are then sampled 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One start-driven conversion on u_dut0.  junk: 0 = quiet inputs while
    // busy, 1 = random start/bin noise while busy, 2 = start with bin=7 on
    // cycles 3 and 5.  None of it may affect the result.
    task automatic run_conv(input int v, input int junk);
        logic [11:0] e;
        e      = ref_bcd(v);
        bin0   = 8'(v);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("trig_busy", 32'(busy0), 32'd1);
        chk("trig_done", 32'(done0), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            if (junk == 1) begin
                start0 = 1'($urandom_range(0, 1));
                bin0   = 8'($urandom);
            end else if (junk == 2 && (i == 3 || i == 5)) begin
                start0 = 1'b1;
                bin0   = 8'd7;
            end else begin
                start0 = 1'b0;
            end
            tick();
            chk("busy", 32'(busy0), 32'(i < 8));
            chk("done", 32'(done0), 32'(i == 8));
            if (i < 8) begin
                chk("hold_bcd", 32'(bcd0), 32'(exp0));
            end else begin
                chk("bcd", 32'(bcd0), 32'(e));
                chk("ovf", 32'(ovf0), 32'(v > 99));
            end
        end
        start0 = 1'b0;
        exp0   = e;
    endtask

    initial begin
        int v;
        int pulses;

        // ---------------- reset ----------------
        rst = 1'b1;
        tick();
        tick();
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_bcd",  32'(bcd0),  32'd0);
        chk("rst_ovf",  32'(ovf0),  32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_bcd1",  32'(bcd1),  32'd0);
        rst = 1'b0;
        tick();

        // ---------------- directed values ----------------
        run_conv(255, 0);
        run_conv(99, 0);
        run_conv(100, 0);
        run_conv(0, 0);
        run_conv(42, 2);

        // ---------------- full sweep, back-to-back, with noise ----------------
        for (int k = 0; k < 256; k++) begin
            run_conv(k, int'($urandom_range(0, 1)));
        end

        // ---------------- random values with idle gaps ----------------
        for (int k = 0; k < 40; k++) begin
            v = int'($urandom_range(0, 255));
            run_conv(v, 1);
            repeat ($urandom_range(0, 3)) begin
                tick();
                chk("idle_done", 32'(done0), 32'd0);
                chk("idle_bcd",  32'(bcd0),  32'(exp0));
            end
        end

        // ---------------- reset in the middle of a conversion ----------------
        bin0   = 8'd200;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy0), 32'd0);
        chk("mid_rst_done", 32'(done0), 32'd0);
        chk("mid_rst_bcd",  32'(bcd0),  32'd0);
        chk("mid_rst_ovf",  32'(ovf0),  32'd0);
        exp0   = 12'h000;
        pulses = 0;
        repeat (12) begin
            tick();
            if (done0) pulses++;
        end
        chk("mid_rst_no_done", 32'(pulses), 32'd0);
        run_conv(13, 0);

        // ---------------- AUTO mode ----------------
        // u_dut1 was reset above with last-converted = 0 and bin1 = 0.
        bin1 = 8'd58;
        tick();
        chk("auto_start_busy", 32'(busy1), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) bin1 = 8'd77;
            tick();
            chk("auto_busy", 32'(busy1), 32'(i < 8));
            chk("auto_done", 32'(done1), 32'(i == 8));
            if (i < 8) chk("auto_hold", 32'(bcd1), 32'h000);
        end
        chk("auto_bcd_58", 32'(bcd1), 32'(ref_bcd(58)));
        chk("auto_ovf_58", 32'(ovf1), 32'd0);
        // The changed bin is picked up on the first IDLE cycle.
        tick();
        chk("auto_retrig_busy", 32'(busy1), 32'd1);
        chk("auto_retrig_done", 32'(done1), 32'd0);
        repeat (8) tick();
        chk("auto_done_77", 32'(done1), 32'd1);
        chk("auto_bcd_77",  32'(bcd1),  32'(ref_bcd(77)));

        pulses = 0;
        repeat (20) begin
            tick();
            if (done1) pulses++;
        end
        chk("auto_quiet", 32'(pulses), 32'd0);

        // Random auto conversions; a coincident start must not add a second one.
        for (int k = 0; k < 10; k++) begin
            v = int'($urandom_range(0, 255));
            if (8'(v) == bin1) v = (v + 1) % 256;
            bin1   = 8'(v);
            start1 = 1'($urandom_range(0, 1));
            tick();
            start1 = 1'b0;
            chk("auto_rnd_busy", 32'(busy1), 32'd1);
            repeat (8) tick();
            chk("auto_rnd_done", 32'(done1), 32'd1);
            chk("auto_rnd_bcd",  32'(bcd1),  32'(ref_bcd(v)));
            chk("auto_rnd_ovf",  32'(ovf1),  32'(v > 99));
            pulses = 0;
            repeat (10) begin
                tick();
                if (done1 || busy1) pulses++;
            end
            chk("auto_rnd_single", 32'(pulses), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bin_to_bcd_seq
`default_nettype wire
